// File: rtl/demux1x4_reg_if.sv
// Bundle of the producer-side and consumer-side signals for demux1x4_reg.
// The slave modport is the demultiplexer. The master modport is its environment.
interface demux1x4_reg_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] in_i;
  logic [1:0]        sel_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] out_a_o;
  logic [DATA_W-1:0] out_b_o;
  logic [DATA_W-1:0] out_c_o;
  logic [DATA_W-1:0] out_d_o;
  logic [3:0]        out_valid_o;
  logic [3:0]        out_ack_i;
  logic [7:0]        stall_cnt_o;

  modport slave (
    input  in_i, sel_i, in_valid_i, out_ack_i,
    output in_ready_o, out_a_o, out_b_o, out_c_o, out_d_o, out_valid_o, stall_cnt_o
  );

  modport master (
    output in_i, sel_i, in_valid_i, out_ack_i,
    input  in_ready_o, out_a_o, out_b_o, out_c_o, out_d_o, out_valid_o, stall_cnt_o
  );
endinterface

// File: rtl/demux1x4_reg.sv
// Registered 1-to-4 demultiplexer with a one-entry valid/ack buffer per channel.
// Optional input stall counter enabled by defining DEMUX_STALL_CNT_EN.
module demux1x4_reg #(
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  demux1x4_reg_if.slave  bus
);

  logic [DATA_W-1:0] data_q [4];
  logic [DATA_W-1:0] data_d [4];
  logic [3:0]        valid_q;
  logic [3:0]        valid_d;
  logic              in_ready;
  logic              xfer;

  // Only the addressed channel gates acceptance; a same-cycle ack frees it.
  assign in_ready = ~valid_q[bus.sel_i] | bus.out_ack_i[bus.sel_i];
  assign xfer     = bus.in_valid_i & in_ready;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      data_d[i] = data_q[i];
    end
    valid_d = valid_q & ~bus.out_ack_i;
    if (xfer) begin
      data_d[bus.sel_i]  = bus.in_i;
      valid_d[bus.sel_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= '0;
      end
      valid_q <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= data_d[i];
      end
      valid_q <= valid_d;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = valid_q;
  assign bus.out_a_o     = data_q[0];
  assign bus.out_b_o     = data_q[1];
  assign bus.out_c_o     = data_q[2];
  assign bus.out_d_o     = data_q[3];

`ifdef DEMUX_STALL_CNT_EN
  logic [7:0] stall_q;
  logic [7:0] stall_d;

  // Saturating count of cycles the producer was held off.
  always_comb begin
    stall_d = stall_q;
    if (bus.in_valid_i && !in_ready && stall_q != 8'hFF) begin
      stall_d = stall_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= 8'h00;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign bus.stall_cnt_o = stall_q;
`else
  assign bus.stall_cnt_o = 8'h00;
`endif

endmodule

// File: tb/tb_demux1x4_reg.sv
// Directed plus randomized bench for demux1x4_reg against a per-channel buffer model.
module tb_demux1x4_reg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  demux1x4_reg_if #(.DATA_W(32)) bus ();
  demux1x4_reg #(.DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  // Reference state: what each consumer buffer holds, and the stall tally.
  logic [31:0] mdata  [4];
  bit          mvalid [4];
  int          mstall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mdata[i]  = 32'h0;
      mvalid[i] = 1'b0;
    end
    mstall = 0;
  endtask

  function automatic logic [31:0] exp_stall();
`ifdef DEMUX_STALL_CNT_EN
    return 32'(mstall);
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic [31:0] exp_valid();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) v[i] = mvalid[i];
    return v;
  endfunction

  task automatic check_outs();
    chk("out_a", bus.out_a_o, mdata[0]);
    chk("out_b", bus.out_b_o, mdata[1]);
    chk("out_c", bus.out_c_o, mdata[2]);
    chk("out_d", bus.out_d_o, mdata[3]);
    chk("out_valid", {28'h0, bus.out_valid_o}, exp_valid());
    chk("stall_cnt", {24'h0, bus.stall_cnt_o}, exp_stall());
  endtask

  task automatic drive(input bit v, input logic [1:0] s, input logic [31:0] d, input logic [3:0] ack);
    bus.in_valid_i = v;
    bus.sel_i      = s;
    bus.in_i       = d;
    bus.out_ack_i  = ack;
  endtask

  // One clock: check in_ready before the edge, advance the model, check state after.
  task automatic tick();
    bit rdy;
    int s;
    #1;
    s   = int'(bus.sel_i);
    rdy = !mvalid[s] || bus.out_ack_i[s];
    chk("in_ready", {31'h0, bus.in_ready_o}, {31'h0, rdy});
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (bus.in_valid_i && rdy && s == i) begin
        mdata[i]  = bus.in_i;
        mvalid[i] = 1'b1;
      end else if (mvalid[i] && bus.out_ack_i[i]) begin
        mvalid[i] = 1'b0;
      end
    end
    if (bus.in_valid_i && !rdy && mstall < 255) mstall++;
    #1;
    check_outs();
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'd0, 32'h0, 4'b0000);
    model_reset();
    #1;
    check_outs();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic routing
    drive(1'b1, 2'd2, 32'hDEADBEEF, 4'b0000);
    tick();
    drive(1'b1, 2'd0, 32'h12345678, 4'b0000);
    tick();
    chk("route_c", bus.out_c_o, 32'hDEADBEEF);
    chk("route_a", bus.out_a_o, 32'h12345678);
    chk("route_valid", {28'h0, bus.out_valid_o}, 32'h5);

    // Asynchronous reset mid-cycle
    drive(1'b0, 2'd0, 32'h0, 4'b0000);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      bus.sel_i = 2'(s);
      #1;
      chk("rdy_after_rst", {31'h0, bus.in_ready_o}, 32'h1);
    end

    // Backpressure on channel 1
    drive(1'b1, 2'd1, 32'hAAAA0000, 4'b0000);
    tick();
    drive(1'b1, 2'd1, 32'hAAAA0001, 4'b0000);
    repeat (3) tick();
    chk("bp_out_b_held", bus.out_b_o, 32'hAAAA0000);
    drive(1'b1, 2'd1, 32'hAAAA0001, 4'b0010);
    tick();
    chk("bp_out_b_new", bus.out_b_o, 32'hAAAA0001);
    drive(1'b0, 2'd0, 32'h0, 4'b0010);
    tick();

    // Full throughput on channel 3
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 2'd3, 32'(k), 4'b1000);
      tick();
      chk("thru_out_d", bus.out_d_o, 32'(k));
    end
    drive(1'b0, 2'd0, 32'h0, 4'b1000);
    tick();

    // Channel independence
    drive(1'b1, 2'd0, 32'h00000055, 4'b0000);
    tick();
    drive(1'b1, 2'd2, 32'h00000066, 4'b0000);
    tick();
    drive(1'b1, 2'd3, 32'h00000077, 4'b0000);
    tick();
    drive(1'b0, 2'd0, 32'h0, 4'b1010);
    tick();
    chk("indep_valid", {28'h0, bus.out_valid_o}, 32'h5);

    // Long stall on full channel 0 drives the counter into saturation
    drive(1'b1, 2'd0, 32'h00000099, 4'b0000);
    repeat (300) tick();
`ifdef DEMUX_STALL_CNT_EN
    chk("stall_sat", {24'h0, bus.stall_cnt_o}, 32'hFF);
`else
    chk("stall_off", {24'h0, bus.stall_cnt_o}, 32'h0);
`endif

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
